// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Parametrised multi-port integer register file with a
//             per-register pending-write scoreboard. Issue reserves a
//             destination register, writeback releases it, and each read
//             port reports whether its register still has writes in flight.
//             Register 0 is hardwired to zero.
//  Ports    : clock      - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             raddr      - NRP read addresses, port i at [i*AW +: AW]
//             rdata      - NRP read data words, port i at [i*XLEN +: XLEN]
//             rbusy      - per read port: register has a pending write
//             wen        - NWP write enables
//             waddr      - NWP write addresses
//             wdata      - NWP write data words
//             rsv_valid  - issue requests a reservation of rsv_addr
//             rsv_addr   - destination register to reserve
//             rsv_ready  - reservation can be accepted this cycle
//             flush      - synchronous clear of every pending counter
//  Options  : REGFILE_SCOREBOARD_BYPASS_EN - when defined, a read whose
//             address matches a same-cycle write returns that write's data
//             and rbusy reflects the post-write pending count.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2,
  parameter int NWP  = 1
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic [NWP-1:0]      wen,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ready,
  input  logic                flush
);

  // Storage and scoreboard state
  logic [XLEN-1:0] r_regs [NREG];
  logic [1:0]      r_cnt  [NREG];

  // Number of active writes hitting each register this cycle (0..2)
  logic [1:0]      w_wcnt    [NREG];
  // Counter value after reservation increment, before write decrement
  logic [2:0]      w_tot     [NREG];
  logic [1:0]      w_cnt_nxt [NREG];
  logic            w_rsv_ready;
  logic            w_rsv_acc;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_wcnt[r] = 2'd0;
      for (int j = 0; j < NWP; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == AW'(r)) && (r != 0)) begin
          w_wcnt[r] = w_wcnt[r] + 2'd1;
        end
      end
    end
  end

  // A saturated counter can still take a reservation when a same-cycle
  // write frees a slot. Register 0 never counts, so it is always ready.
  assign w_rsv_ready = !((r_cnt[rsv_addr] == 2'd3) && (w_wcnt[rsv_addr] == 2'd0));
  assign w_rsv_acc   = rsv_valid && w_rsv_ready && (rsv_addr != '0);
  assign rsv_ready   = w_rsv_ready || !rst_n;

  // Net counter update with floor at zero. The ready rule guarantees the
  // result never exceeds 3.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_tot[r] = {1'b0, r_cnt[r]};
      if (w_rsv_acc && (rsv_addr == AW'(r))) begin
        w_tot[r] = w_tot[r] + 3'd1;
      end
      if (w_tot[r] > {1'b0, w_wcnt[r]}) begin
        w_cnt_nxt[r] = 2'(w_tot[r] - {1'b0, w_wcnt[r]});
      end else begin
        w_cnt_nxt[r] = 2'd0;
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_BYPASS_EN
  // Pending count as seen after this cycle's writebacks (reservations excluded)
  logic [1:0] w_cnt_pw [NREG];
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cnt_pw[r] = (r_cnt[r] > w_wcnt[r]) ? (r_cnt[r] - w_wcnt[r]) : 2'd0;
    end
  end
`endif

  // Read ports
  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    logic            w_busy;

    assign w_ra = raddr[i*AW +: AW];

    always_comb begin
      w_rd   = r_regs[w_ra];
      w_busy = (r_cnt[w_ra] != 2'd0);
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
      // Ascending scan so the highest-numbered write port wins
      for (int j = 0; j < NWP; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == w_ra)) begin
          w_rd = wdata[j*XLEN +: XLEN];
        end
      end
      w_busy = (w_cnt_pw[w_ra] != 2'd0);
`endif
      // Register 0 and the reset window always read as idle zero
      if ((w_ra == '0) || !rst_n) begin
        w_rd   = '0;
        w_busy = 1'b0;
      end
    end

    assign rdata[i*XLEN +: XLEN] = w_rd;
    assign rbusy[i]              = w_busy;
  end

  // State update: reset > flush > counter arithmetic. Data writes still
  // land in a flush cycle; later write ports overwrite earlier ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= 2'd0;
      end
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
          r_regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= flush ? 2'd0 : w_cnt_nxt[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_scoreboard
//  Purpose  : Self-checking bench for regfile_scoreboard (NRP=2, NWP=2).
//             A driver issues directed and random cycles and pushes the
//             reference model's expected outputs into a queue; a monitor
//             pops and compares them against the DUT each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;
  localparam int NWP  = 2;

  logic                clock = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRP*AW-1:0]   raddr = '0;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic [NWP-1:0]      wen = '0;
  logic [NWP*AW-1:0]   waddr = '0;
  logic [NWP*XLEN-1:0] wdata = '0;
  logic                rsv_valid = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                rsv_ready;
  logic                flush = 1'b0;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .NWP(NWP)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .flush     (flush)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NRP*XLEN-1:0] rdata;
    logic [NRP-1:0]      rbusy;
    logic                rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: architectural register values and pending-write counts
  logic [XLEN-1:0] m_mem [NREG];
  int              m_cnt [NREG];

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
  end

  // How many active writes hit register a this cycle
  function automatic int nwr(int a);
    int n = 0;
    for (int j = 0; j < NWP; j++) begin
      if (wen[j] && (int'(waddr[j*AW +: AW]) == a) && (a != 0)) n++;
    end
    return n;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    wen       = '0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wen[p]                 = 1'b1;
    waddr[p*AW +: AW]      = AW'(a);
    wdata[p*XLEN +: XLEN]  = d;
  endtask

  task automatic rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic rsv(input int a);
    rsv_valid = 1'b1;
    rsv_addr  = AW'(a);
  endtask

  // One clock cycle: predict outputs for the current inputs, queue them,
  // then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    int   ra;
    int   left;
    bit   acc;
    int   newc [NREG];
    e = '0;
    if (!rst_n) begin
      e.rdy = 1'b1;
    end else begin
      e.rdy = !((m_cnt[rsv_addr] == 3) && (nwr(int'(rsv_addr)) == 0));
      for (int i = 0; i < NRP; i++) begin
        ra = int'(raddr[i*AW +: AW]);
        if (ra != 0) begin
          e.rdata[i*XLEN +: XLEN] = m_mem[ra];
          e.rbusy[i]              = (m_cnt[ra] != 0);
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
          for (int j = 0; j < NWP; j++) begin
            if (wen[j] && (int'(waddr[j*AW +: AW]) == ra)) e.rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          end
          left = m_cnt[ra] - nwr(ra);
          e.rbusy[i] = (left > 0);
`endif
        end
      end
    end
    acc = rsv_valid && e.rdy && (rsv_addr != '0);
    exp_q.push_back(e);

    @(posedge clock);
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = '0;
        m_cnt[r] = 0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        newc[r] = m_cnt[r] + ((acc && (int'(rsv_addr) == r)) ? 1 : 0) - nwr(r);
        if (newc[r] < 0 || flush) newc[r] = 0;
      end
      for (int r = 0; r < NREG; r++) m_cnt[r] = newc[r];
      for (int j = 0; j < NWP; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] != '0)) m_mem[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      end
    end
    #1;
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  exp_t e_mon;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      for (int i = 0; i < NRP; i++) begin
        n_checks++;
        if (rdata[i*XLEN +: XLEN] !== e_mon.rdata[i*XLEN +: XLEN])
          $display("FAIL rdata%0d @%0t: got %h expected %h", i, $time,
                   rdata[i*XLEN +: XLEN], e_mon.rdata[i*XLEN +: XLEN]);
        else n_pass++;
        n_checks++;
        if (rbusy[i] !== e_mon.rbusy[i])
          $display("FAIL rbusy%0d @%0t: got %b expected %b", i, $time, rbusy[i], e_mon.rbusy[i]);
        else n_pass++;
      end
      n_checks++;
      if (rsv_ready !== e_mon.rdy)
        $display("FAIL rsv_ready @%0t: got %b expected %b", $time, rsv_ready, e_mon.rdy);
      else n_pass++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    idle();
    rst_n = 1'b0;
    @(posedge clock);
    #1;

    // Reset window: outputs forced idle even with live stimulus
    idle(); rd(0, 3); rd(1, 5); wr(0, 3, 64'h77); rsv(3); step();
    idle(); rd(0, 0); rd(1, 31); step();
    rst_n = 1'b1;

    // Every address reads zero and not busy after reset
    for (int k = 0; k < NREG/2; k++) begin
      idle(); rd(0, 2*k); rd(1, 2*k+1); rsv_addr = AW'(2*k); step();
    end

    // Basic write/read and register 0
    idle(); wr(0, 5, 64'hDEADBEEF_00000001); rd(0, 5); step();
    idle(); rd(0, 5); rd(1, 5); step();
    idle(); wr(0, 0, 64'h1234); rd(0, 0); step();
    idle(); rd(1, 0); rsv(0); step();
    idle(); rsv_addr = '0; rd(0, 0); step();

    // Saturate x7, blocked reservation, then drain with writes
    for (int k = 0; k < 3; k++) begin
      idle(); rsv(7); rd(0, 7); step();
    end
    idle(); rsv(7); rd(0, 7); step();
    idle(); wr(0, 7, 64'h1); rsv_addr = AW'(7); rd(0, 7); step();
    idle(); rsv_addr = AW'(7); rd(0, 7); step();
    idle(); wr(1, 7, 64'h2); rd(0, 7); step();
    idle(); wr(0, 7, 64'h3); rd(0, 7); rd(1, 7); step();
    idle(); rd(0, 7); step();

    // Saturated counter with same-cycle write accepts a reservation
    for (int k = 0; k < 3; k++) begin
      idle(); rsv(11); step();
    end
    idle(); rsv(11); wr(1, 11, 64'hB1); rd(0, 11); step();
    idle(); rsv_addr = AW'(11); rd(0, 11); step();

    // Reservation and write to the same register cancel
    idle(); rsv(9); step();
    idle(); rsv(9); wr(0, 9, 64'h9); rd(0, 9); step();
    idle(); rd(0, 9); step();

    // Both write ports hit x3: port 1 wins data, counter drops by two
    idle(); rsv(3); step();
    idle(); wr(0, 3, 64'hA); wr(1, 3, 64'hB); rd(0, 3); rd(1, 3); step();
    idle(); rd(0, 3); rd(1, 3); step();

    // Flush beats a same-cycle reservation
    idle(); rsv(4); step();
    idle(); rsv(8); rd(0, 4); step();
    idle(); rsv(10); flush = 1'b1; rd(0, 4); rd(1, 8); step();
    idle(); rd(0, 10); rd(1, 4); wr(0, 4, 64'h44); step();
    idle(); rd(0, 4); rd(1, 10); step();

    // Write while reading a pending register (bypass-dependent)
    idle(); rsv(6); step();
    idle(); wr(0, 6, 64'h55); rd(0, 6); step();
    idle(); rd(0, 6); step();

    // Reset in the middle of activity discards all state
    idle(); rsv(12); wr(0, 13, 64'hCAFE); step();
    idle(); rsv(12); rd(0, 12); rd(1, 13); step();
    rst_n = 1'b0;
    idle(); rd(0, 12); rd(1, 13); step();
    rst_n = 1'b1;
    idle(); rd(0, 12); rd(1, 13); step();

    // Random traffic concentrated on a few registers to create hazards
    for (int n = 0; n < 1500; n++) begin
      idle();
      for (int i = 0; i < NRP; i++) rd(i, int'(rand_addr()));
      for (int j = 0; j < NWP; j++) begin
        if ($urandom_range(0, 2) == 0) wr(j, int'(rand_addr()), XLEN'({$urandom, $urandom}));
      end
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = rand_addr();
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write, two-read integer register file, for the pipelined and dual-issue core.
- Adds configurable width, depth, and read/write port counts.
- Adds a per-register pending-write scoreboard: issue reserves a destination, writeback releases it, and readers see a busy flag for hazard stalls.
- Sits between the decode/issue stage (reads and reservations) and the writeback stage (writes).

Parameters:
XLEN, 64, data width of each register.
NREG, 32, register count; power of 2, >=2; register 0 hardwired to zero.
AW, 5, address width, equal to log2(NREG).
NRP, 2, number of read ports (1..4).
NWP, 1, number of write ports (1..2).

Ports:
clock  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
raddr  in  NRP*AW  read addresses; port i uses bits [i*AW +: AW].
rdata  out  NRP*XLEN  read data for each port.
rbusy  out  NRP  port i's register has at least one pending write.
wen  in  NWP  write enables.
waddr  in  NWP*AW  write addresses.
wdata  in  NWP*XLEN  write data.
rsv_valid  in  1  issue requests reservation of rsv_addr.
rsv_addr  in  AW  destination register to reserve.
rsv_ready  out  1  reservation can be accepted this cycle.
flush  in  1  synchronous clear of all pending counters (pipeline flush).

Behaviour:
- Reset (rst_n low, async):
  - All registers go to 0 and all pending counters go to 0.
  - Outputs while in reset: rdata=0, rbusy=0, rsv_ready=1.
  - Release is synchronous to clock. Reset mid-operation discards all pending state.
- Register 0:
  - Always reads 0 with rbusy=0.
  - Writes to it are ignored.
  - Reservations of it are accepted (rsv_ready=1) but do not change any state.
- Reads:
  - Combinational, zero latency.
  - rdata[i] is reg[raddr_i], subject to bypass (see Optional Feature).
- Writes:
  - Take effect at the clock edge when wen[j]=1 and waddr_j!=0.
  - If both write ports target the same address in one cycle, port NWP-1 wins for data.
  - Both ports still decrement that register's counter (each by 1, floor 0).
- Pending counter, per register:
  - 2 bits wide, value 0..3.
  - Next value = cnt + (accepted reservation ? 1 : 0) - (number of writes to that register this cycle), floored at 0.
  - Reservation and write to the same register in one cycle: net change applied. For example, cnt=1 with 1 rsv and 1 write leaves cnt=1.
  - A write to a register with cnt=0 leaves cnt at 0 (no underflow).
- rsv_ready:
  - Low when cnt[rsv_addr]==3 and no write to rsv_addr occurs this cycle. A same-cycle write frees a slot, so rsv_ready stays high.
  - A reservation is accepted when rsv_valid && rsv_ready.
  - rsv_valid with rsv_ready low has no effect; issue must hold and retry.
- rbusy[i]:
  - Equals (cnt[raddr_i]!=0), combinational from the registered counter.
  - Is not cleared by a same-cycle write unless bypass is enabled.
- flush:
  - At the clock edge, all counters go to 0. flush overrides same-cycle reservations and write decrements.
  - Register data writes in the flush cycle still occur.
- No internal state machine beyond the counters.
- Simultaneous events resolve in this order: reset > flush > counter arithmetic.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_BYPASS_EN.
- Defined (bypass on):
  - A read whose address matches an active same-cycle write (non-zero address) returns that wdata; the highest write port wins.
  - rbusy[i] is computed from the post-write count, so it is 0 if that write brings the counter to 0.
- Undefined (bypass off):
  - Reads return the stored value; the write is visible from the next cycle.
  - rbusy reflects the registered count only.

Test Plan:
- Reset then read all ports at addresses 0..31 -> rdata=0, rbusy=0, rsv_ready=1.
- Write x5=0xDEADBEEF_00000001, next cycle raddr0=5 -> rdata0=0xDEADBEEF_00000001. Write x0=0x1234, then read x0 -> 0.
- Reserve x7 three times -> cnt=3, rsv_ready=0 when rsv_addr=7, rbusy=1 on a read of x7. One write to x7 -> cnt=2, rsv_ready=1. Two more writes -> rbusy=0.
- Same cycle, cnt[9]=1: rsv x9 plus write x9 -> cnt stays 1. NWP=2 with both ports writing x3 (0xA, 0xB) -> x3=0xB, cnt[3] decremented by 2 with floor at 0.
- Reserve x4 and x8, assert flush with a simultaneous rsv of x10 -> all rbusy=0 and cnt[10]=0. Later writes to x4 keep cnt at 0.
- With bypass on: write x6=0x55 while reading x6 with cnt[6]=1 -> rdata=0x55, rbusy=0 in the same cycle. With bypass off: rdata is the old value, rbusy=1, then 0x55 and rbusy=0 the next cycle.
